// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx -- UART serial transmitter (8 data bits, 1 stop bit, optional parity)
//
// Serialises one byte per request onto an idle-high line: start bit (0),
// eight data bits LSB first, an optional parity bit, then one stop bit (1).
// Every bit lasts CLKS_PER_BIT clock cycles.
//
// Parameters:
//   CLK_FREQ  system clock frequency in Hz
//   BAUD      line rate in bit/s
//   PARITY    0 = none, 1 = even, 2 = odd (any other value means none)
//
// Ports:
//   in_clk     system clock, rising edge
//   in_rst     asynchronous active-low reset
//   in_s_en    send request (level-sampled)
//   in_data    byte to send, sampled only in the accept cycle
//   out_tx     serial line, idle high, driven straight from a flop
//   out_s_bs   busy while a frame is on the line
//   out_s_rd   one-cycle pulse as the stop bit completes
//   dbg_state  current FSM state (IDLE=0, START=1, DATA=2, PAR=3, STOP=4)
//
// Handshake: a request is accepted on any rising edge where in_s_en=1 and the
// FSM is in IDLE (out_s_bs=0); in_data is captured on that same edge. Requests
// seen while busy are dropped, not queued. The IDLE cycle that carries the
// out_s_rd pulse is itself an accept cycle, so a held in_s_en streams frames
// with exactly one idle-high cycle after each full stop bit.
// ---------------------------------------------------------------------------
module uart_tx #(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int PARITY   = 0
) (
  input  logic       in_clk,
  input  logic       in_rst,
  input  logic       in_s_en,
  input  logic [7:0] in_data,
  output logic       out_tx,
  output logic       out_s_bs,
  output logic       out_s_rd,
  output logic [2:0] dbg_state
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  // Illegal PARITY values behave as "none".
  localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
  localparam bit PAR_ODD = (PARITY == 2);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;

  assign dbg_state = state;

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      out_tx   <= 1'b1;
      out_s_bs <= 1'b0;
      out_s_rd <= 1'b0;
    end else begin
      out_s_rd <= 1'b0;
      if (state == IDLE) begin
        if (in_s_en) begin
          shreg    <= in_data;
          // Parity comes from the byte as accepted, so later in_data
          // changes cannot disturb it.
          par_bit  <= (^in_data) ^ PAR_ODD;
          baud_cnt <= '0;
          bit_cnt  <= '0;
          out_tx   <= 1'b0;
          out_s_bs <= 1'b1;
          state    <= START;
        end
      end else if (baud_cnt == BAUD_LAST) begin
        // End of the current bit period: load the next bit onto the line.
        baud_cnt <= '0;
        case (state)
          START: begin
            out_tx <= shreg[0];
            shreg  <= {1'b0, shreg[7:1]};
            state  <= DATA;
          end
          DATA: begin
            if (bit_cnt == 3'd7) begin
              bit_cnt <= 3'd0;
              if (PAR_EN) begin
                out_tx <= par_bit;
                state  <= PAR;
              end else begin
                out_tx <= 1'b1;
                state  <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              out_tx  <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end
          PAR: begin
            out_tx <= 1'b1;
            state  <= STOP;
          end
          STOP: begin
            out_tx   <= 1'b1;
            out_s_bs <= 1'b0;
            out_s_rd <= 1'b1;
            state    <= IDLE;
          end
          default: begin
            out_tx   <= 1'b1;
            out_s_bs <= 1'b0;
            state    <= IDLE;
          end
        endcase
      end else begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

endmodule
